// File: rtl/axi4_ddr_read_splitter_pkg.sv
// Shared AXI encodings, page constant, response and FSM types for the DDR read splitter.
package axi4_ddr_read_splitter_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam logic [12:0] PAGE_BYTES_C = 13'd4096;

    function automatic logic [8:0] min_beats(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_ddr_read_splitter_if.sv
// AXI4 read-only bus (AR + R channels) with master and slave views.
interface axi4_ddr_read_splitter_if #(
    parameter int id_width_p   = 6,
    parameter int addr_width_p = 64,
    parameter int data_width_p = 512
);
    logic [id_width_p-1:0]   arid;
    logic [addr_width_p-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [id_width_p-1:0]   rid;
    logic [data_width_p-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_burst_len_calc.sv
// Combinational sub-burst sizing: caps INCR bursts at max_beats_p and the 4 KB page end.
module axi4_burst_len_calc
    import axi4_ddr_read_splitter_pkg::*;
#(
    parameter int addr_width_p = 64,
    parameter int max_beats_p  = 16
) (
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [2:0]              size_i,
    input  logic [1:0]              burst_i,
    input  logic [8:0]              remaining_i,
    output logic [8:0]              beats_o,
    output logic [addr_width_p-1:0] next_addr_o
);
    logic [12:0]             page_left_s;
    logic [12:0]             page_beats_s;
    logic [8:0]              cap_s;
    logic [8:0]              beats_s;
    logic [addr_width_p-1:0] step_s;

    // Beats available before the page end, the per-sub-burst cap and the resulting step.
    always_comb begin
        page_left_s  = PAGE_BYTES_C - {1'b0, addr_i[11:0]};
        page_beats_s = page_left_s >> size_i;
        if (page_beats_s > 13'(max_beats_p)) begin
            cap_s = 9'(max_beats_p);
        end else begin
            cap_s = page_beats_s[8:0];
        end
        if (burst_i == BURST_INCR) begin
            beats_s = min_beats(remaining_i, cap_s);
        end else begin
            beats_s = remaining_i;
        end
        step_s      = {{(addr_width_p-9){1'b0}}, beats_s} << size_i;
        next_addr_o = addr_i + step_s;
        beats_o     = beats_s;
    end
endmodule

// File: rtl/axi4_ddr_read_splitter.sv
// AXI4 read splitter: one upstream burst becomes page/length-bounded sub-bursts, R merged back.
// Build option AXI_SPLIT_RESP_STICKY_EN makes rresp report the worst response of the burst so far.
module axi4_ddr_read_splitter
    import axi4_ddr_read_splitter_pkg::*;
#(
    parameter int id_width_p        = 6,
    parameter int addr_width_p      = 64,
    parameter int data_width_p      = 512,
    parameter int max_beats_p       = 16,
    parameter int max_outstanding_p = 4
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    axi4_ddr_read_splitter_if.slave  s_axi,
    axi4_ddr_read_splitter_if.master m_axi
);
    localparam int ost_w_lp = $clog2(max_outstanding_p + 1);
    localparam logic [ost_w_lp-1:0] ost_max_lp = ost_w_lp'(max_outstanding_p);

    state_e                  state_q, state_d;
    logic [id_width_p-1:0]   id_q, id_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [8:0]              total_q, total_d;
    logic [8:0]              remaining_q, remaining_d;
    logic [8:0]              delivered_q, delivered_d;
    logic [ost_w_lp-1:0]     outstanding_q, outstanding_d;
    logic                    arready_q, arready_d;

    logic [8:0]              beats_s;
    logic [addr_width_p-1:0] next_addr_s;
    logic                    ar_acc_s, m_arvalid_s, m_ar_hs_s, r_hs_s, r_active_s, last_beat_s;
    logic                    unused_rid_s;

    axi4_burst_len_calc #(
        .addr_width_p (addr_width_p),
        .max_beats_p  (max_beats_p)
    ) u_len_calc (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .remaining_i (remaining_q),
        .beats_o     (beats_s),
        .next_addr_o (next_addr_s)
    );

    assign r_active_s   = (state_q != ST_IDLE);
    assign m_arvalid_s  = (state_q == ST_ISSUE) && (outstanding_q != ost_max_lp);
    assign ar_acc_s     = arready_q && s_axi.arvalid;
    assign m_ar_hs_s    = m_arvalid_s && m_axi.arready;
    assign r_hs_s       = r_active_s && m_axi.rvalid && s_axi.rready;
    assign last_beat_s  = (delivered_q == (total_q - 9'd1));
    assign unused_rid_s = ^m_axi.rid;

    // FSM next state, burst context capture and upstream beat counting.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        burst_d     = burst_q;
        total_d     = total_q;
        remaining_d = remaining_q;
        delivered_d = delivered_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_acc_s) begin
                    id_d        = s_axi.arid;
                    addr_d      = s_axi.araddr;
                    size_d      = s_axi.arsize;
                    burst_d     = s_axi.arburst;
                    total_d     = {1'b0, s_axi.arlen} + 9'd1;
                    remaining_d = {1'b0, s_axi.arlen} + 9'd1;
                    delivered_d = 9'd0;
                    state_d     = ST_ISSUE;
                end else begin
                    delivered_d = 9'd0;
                end
            end
            ST_ISSUE: begin
                if (m_ar_hs_s) begin
                    remaining_d = remaining_q - beats_s;
                    addr_d      = next_addr_s;
                    if (remaining_q == beats_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
                if (r_hs_s) begin
                    delivered_d = delivered_q + 9'd1;
                end else begin
                    delivered_d = delivered_q;
                end
            end
            ST_DRAIN: begin
                if (r_hs_s && last_beat_s) begin
                    delivered_d = 9'd0;
                    state_d     = ST_IDLE;
                end else if (r_hs_s) begin
                    delivered_d = delivered_q + 9'd1;
                end else begin
                    delivered_d = delivered_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outstanding sub-burst count and the registered upstream AR ready.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({m_ar_hs_s, r_hs_s && m_axi.rlast})
            2'b10:   outstanding_d = outstanding_q + ost_w_lp'(1);
            2'b01:   outstanding_d = outstanding_q - ost_w_lp'(1);
            default: outstanding_d = outstanding_q;
        endcase
        arready_d = (state_d == ST_IDLE);
    end

    // State and context registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q       <= ST_IDLE;
            id_q          <= '0;
            addr_q        <= '0;
            size_q        <= 3'd0;
            burst_q       <= 2'd0;
            total_q       <= 9'd0;
            remaining_q   <= 9'd0;
            delivered_q   <= 9'd0;
            outstanding_q <= '0;
            arready_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            burst_q       <= burst_d;
            total_q       <= total_d;
            remaining_q   <= remaining_d;
            delivered_q   <= delivered_d;
            outstanding_q <= outstanding_d;
            arready_q     <= arready_d;
        end
    end

    assign s_axi.arready = arready_q;
    assign m_axi.arid    = id_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = 8'(beats_s - 9'd1);
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = burst_q;
    assign m_axi.arvalid = m_arvalid_s;

    assign m_axi.rready  = r_active_s && s_axi.rready;
    assign s_axi.rvalid  = r_active_s && m_axi.rvalid;
    assign s_axi.rid     = id_q;
    assign s_axi.rdata   = m_axi.rdata;
    assign s_axi.rlast   = r_active_s && last_beat_s;

`ifdef AXI_SPLIT_RESP_STICKY_EN
    logic [1:0] resp_q, resp_d;

    // Worst response seen in the current burst; cleared whenever the FSM is (re)entering IDLE.
    always_comb begin
        if (state_d == ST_IDLE) begin
            resp_d = RESP_OKAY;
        end else if (r_hs_s) begin
            resp_d = resp_q | m_axi.rresp;
        end else begin
            resp_d = resp_q;
        end
    end

    // Sticky response register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            resp_q <= RESP_OKAY;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign s_axi.rresp = resp_q | m_axi.rresp;
`else
    assign s_axi.rresp = m_axi.rresp;
`endif
endmodule

// File: tb/tb_axi4_ddr_read_splitter.sv
// Randomized self-checking bench for axi4_ddr_read_splitter with a split/merge reference model.
module tb_axi4_ddr_read_splitter;
    import axi4_ddr_read_splitter_pkg::*;

    localparam int IDW = 6, AW = 64, DW = 512, MAXB = 16, MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_ddr_read_splitter_if #(.id_width_p(IDW), .addr_width_p(AW), .data_width_p(DW)) s_if();
    axi4_ddr_read_splitter_if #(.id_width_p(IDW), .addr_width_p(AW), .data_width_p(DW)) m_if();

    axi4_ddr_read_splitter #(
        .id_width_p(IDW), .addr_width_p(AW), .data_width_p(DW),
        .max_beats_p(MAXB), .max_outstanding_p(MAXO)
    ) dut (
        .clk_i(clk), .resetn_i(rst_n), .s_axi(s_if), .m_axi(m_if)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ar_t;

    ar_t exp_ar_q[$];
    ar_t slv_q[$];

    int n_cmp = 0, n_bad = 0;
    int ar_mode, rr_mode, rv_mode;
    bit in_rst = 1'b1;
    bit req_pending = 1'b0;
    logic [IDW-1:0] req_id;
    logic [AW-1:0]  req_addr;
    logic [7:0]     req_len;
    logic [2:0]     req_size;
    logic [1:0]     req_burst;
    int cur_total, up_cnt, n_rlast, bar_cnt, exp_n_ar, err_beat;
    int slv_beat = 0, slv_up = 0, tb_ost = 0, cyc = 0;
    bit done;
    bit mav_prev = 1'b0, rv_hold = 1'b0;
    logic [AW-1:0] mav_addr;
    logic [7:0]    mav_len;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
    endfunction

    // Reference split: each cut is the smallest of remaining, MAXB and bytes-to-page-end / bytes-per-beat.
    task automatic build_exp(input logic [AW-1:0] a0, input int len, input int size, input logic [1:0] burst);
        int rem, b, page;
        logic [AW-1:0] a;
        ar_t e;
        exp_ar_q.delete();
        a = a0;
        rem = len + 1;
        if (burst != BURST_INCR) begin
            e.addr = a; e.len = 8'(len); e.size = 3'(size); e.burst = burst;
            exp_ar_q.push_back(e);
        end else begin
            while (rem > 0) begin
                page = (4096 - int'(a[11:0])) / (1 << size);
                b = rem;
                if (b > MAXB) b = MAXB;
                if (b > page) b = page;
                e.addr = a; e.len = 8'(b - 1); e.size = 3'(size); e.burst = burst;
                exp_ar_q.push_back(e);
                a = a + AW'(b * (1 << size));
                rem -= b;
            end
        end
        exp_n_ar = exp_ar_q.size();
    endtask

    // Bus agent: drives both sides each negedge, then records the handshakes the next posedge will take.
    initial begin : agent
        logic [AW-1:0] ba;
        logic [1:0]    exp_resp;
        s_if.arvalid = 1'b0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = 8'd0;
        s_if.arsize = 3'd0; s_if.arburst = 2'd0; s_if.rready = 1'b0;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rid = '0; m_if.rdata = '0;
        m_if.rresp = 2'd0; m_if.rlast = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_rst) begin
                s_if.arvalid = 1'b0; s_if.rready = 1'b0; m_if.arready = 1'b0; m_if.rvalid = 1'b0;
                mav_prev = 1'b0; rv_hold = 1'b0;
            end else begin
                s_if.arvalid = req_pending; s_if.arid = req_id; s_if.araddr = req_addr;
                s_if.arlen = req_len; s_if.arsize = req_size; s_if.arburst = req_burst;
                case (ar_mode)
                    0:       m_if.arready = ($urandom_range(0, 2) != 0);
                    1:       m_if.arready = 1'b1;
                    default: m_if.arready = 1'b0;
                endcase
                case (rr_mode)
                    0:       s_if.rready = ($urandom_range(0, 3) != 0);
                    1:       s_if.rready = 1'b1;
                    default: s_if.rready = ((cyc % 2) == 1);
                endcase
                if (!rv_hold) begin
                    if (rv_mode != 2 && slv_q.size() > 0 && (rv_mode == 1 || $urandom_range(0, 3) != 0)) begin
                        ba = (slv_q[0].burst == BURST_FIXED) ? slv_q[0].addr
                                                             : slv_q[0].addr + (AW'(slv_beat) << slv_q[0].size);
                        m_if.rvalid = 1'b1;
                        m_if.rdata  = mkdata(ba);
                        m_if.rresp  = (slv_up == err_beat) ? RESP_SLVERR : RESP_OKAY;
                        m_if.rlast  = (slv_beat == int'(slv_q[0].len));
                        m_if.rid    = req_id;
                    end else begin
                        m_if.rvalid = 1'b0;
                    end
                end
                #1;
                if (mav_prev) begin
                    check_eq("ar_hold_valid", m_if.arvalid, 1'b1);
                    check_eq("ar_hold_addr", m_if.araddr, mav_addr);
                    check_eq("ar_hold_len", m_if.arlen, mav_len);
                end
                if (s_if.arvalid && s_if.arready) req_pending = 1'b0;
                if (m_if.arvalid && m_if.arready) begin
                    ar_t got;
                    check_eq("ost_below_max", tb_ost < MAXO, 1'b1);
                    check_eq("ar_expected", exp_ar_q.size() > 0, 1'b1);
                    if (exp_ar_q.size() > 0) begin
                        check_eq("ar_addr", m_if.araddr, exp_ar_q[0].addr);
                        check_eq("ar_len", m_if.arlen, exp_ar_q[0].len);
                        check_eq("ar_size", m_if.arsize, exp_ar_q[0].size);
                        check_eq("ar_burst", m_if.arburst, exp_ar_q[0].burst);
                        void'(exp_ar_q.pop_front());
                    end
                    check_eq("ar_id", m_if.arid, req_id);
                    got.addr = m_if.araddr; got.len = m_if.arlen; got.size = m_if.arsize; got.burst = m_if.arburst;
                    slv_q.push_back(got);
                    tb_ost++; bar_cnt++;
                end
                if (m_if.rvalid && m_if.rready) begin
                    if (m_if.rlast) begin
                        void'(slv_q.pop_front());
                        slv_beat = 0;
                        tb_ost--;
                    end else begin
                        slv_beat++;
                    end
                    slv_up++;
                end
                rv_hold = m_if.rvalid && !m_if.rready;
                if (s_if.rvalid && s_if.rready) begin
                    check_eq("beat_in_range", up_cnt < cur_total, 1'b1);
                    ba = (req_burst == BURST_FIXED) ? req_addr : req_addr + (AW'(up_cnt) << req_size);
`ifdef AXI_SPLIT_RESP_STICKY_EN
                    exp_resp = (err_beat >= 0 && up_cnt >= err_beat) ? RESP_SLVERR : RESP_OKAY;
`else
                    exp_resp = (up_cnt == err_beat) ? RESP_SLVERR : RESP_OKAY;
`endif
                    check_eq("r_data", s_if.rdata, mkdata(ba));
                    check_eq("r_id", s_if.rid, req_id);
                    check_eq("r_last", s_if.rlast, up_cnt == cur_total - 1);
                    check_eq("r_resp", s_if.rresp, exp_resp);
                    if (s_if.rlast) n_rlast++;
                    up_cnt++;
                    if (up_cnt == cur_total) done = 1'b1;
                end
                mav_prev = m_if.arvalid && !m_if.arready;
                mav_addr = m_if.araddr;
                mav_len  = m_if.arlen;
            end
        end
    end

    task automatic start_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input int len,
                               input int size, input logic [1:0] burst, input int err);
        build_exp(addr, len, size, burst);
        cur_total = len + 1; up_cnt = 0; slv_up = 0; n_rlast = 0; bar_cnt = 0; done = 1'b0;
        err_beat = err;
        req_id = id; req_addr = addr; req_len = 8'(len); req_size = 3'(size); req_burst = burst;
        req_pending = 1'b1;
        @(negedge clk);
        #2;
        check_eq("arready_idle", s_if.arready, 1'b1);
    endtask

    task automatic wait_burst(input int plan_n);
        int k = 0;
        while (!done && k < 8000) begin
            @(posedge clk);
            k++;
        end
        check_eq("burst_done", done, 1'b1);
        check_eq("ar_count", bar_cnt, exp_n_ar);
        check_eq("rlast_count", n_rlast, 1);
        if (plan_n >= 0) check_eq("plan_ar_count", bar_cnt, plan_n);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : seq
        int k, sz, ln, er;
        logic [AW-1:0] a;
        ar_mode = 1; rr_mode = 1; rv_mode = 1; err_beat = -1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_arready", s_if.arready, 1'b0);
        check_eq("rst_s_rvalid", s_if.rvalid, 1'b0);
        check_eq("rst_m_arvalid", m_if.arvalid, 1'b0);
        check_eq("rst_m_rready", m_if.rready, 1'b0);
        @(posedge clk); #2; rst_n = 1'b1; in_rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("idle_s_arready", s_if.arready, 1'b1);
        check_eq("idle_m_arvalid", m_if.arvalid, 1'b0);

        start_burst(6'h01, 64'h1000, 63, 6, BURST_INCR, -1);      wait_burst(4);
        start_burst(6'h02, 64'h0FC0, 3, 6, BURST_INCR, -1);       wait_burst(2);
        start_burst(6'h03, 64'h2000, 255, 0, BURST_INCR, -1);     wait_burst(16);
        start_burst(6'h04, 64'h5555_0040, 0, 3, BURST_INCR, -1);  wait_burst(1);
        start_burst(6'h05, 64'h0FC0, 15, 6, BURST_FIXED, -1);     wait_burst(1);
        start_burst(6'h06, 64'h7F80, 7, 6, BURST_WRAP, -1);       wait_burst(1);

        ar_mode = 2; rv_mode = 2;
        start_burst(6'h07, 64'h3000, 127, 6, BURST_INCR, -1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("stall_no_ar", bar_cnt, 0);
        check_eq("stall_arvalid", m_if.arvalid, 1'b1);
        ar_mode = 1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("ost_full_ar_count", bar_cnt, MAXO);
        check_eq("ost_full_arvalid", m_if.arvalid, 1'b0);
        rv_mode = 1;
        wait_burst(8);

        rr_mode = 2;
        start_burst(6'h08, 64'h8000, 31, 6, BURST_INCR, -1);      wait_burst(2);
        rr_mode = 1;
        start_burst(6'h09, 64'h9000, 15, 6, BURST_INCR, 5);       wait_burst(1);
        start_burst(6'h0A, 64'hA000, 15, 6, BURST_INCR, -1);      wait_burst(1);

        ar_mode = 0; rr_mode = 0; rv_mode = 0;
        for (int i = 0; i < 25; i++) begin
            sz = $urandom_range(0, 6);
            a  = {$urandom, $urandom};
            a  = a & ~((64'd1 << sz) - 64'd1);
            ln = (i % 2 == 1) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            er = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ln) : -1;
            start_burst(IDW'($urandom), a, ln, sz, BURST_INCR, er);
            wait_burst(-1);
        end

        ar_mode = 1; rr_mode = 1; rv_mode = 2;
        start_burst(6'h0B, 64'h1000, 63, 6, BURST_INCR, -1);
        k = 0;
        while (bar_cnt < 2 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check_eq("pre_reset_ars", bar_cnt >= 2, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0; in_rst = 1'b1;
        #1;
        check_eq("mid_rst_s_arready", s_if.arready, 1'b0);
        check_eq("mid_rst_s_rvalid", s_if.rvalid, 1'b0);
        check_eq("mid_rst_m_arvalid", m_if.arvalid, 1'b0);
        check_eq("mid_rst_m_rready", m_if.rready, 1'b0);
        req_pending = 1'b0; exp_ar_q.delete(); slv_q.delete(); slv_beat = 0; tb_ost = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1; in_rst = 1'b0; rv_mode = 1;
        @(posedge clk); @(posedge clk); #1;
        check_eq("post_rst_s_arready", s_if.arready, 1'b1);
        start_burst(6'h0C, 64'h1000, 63, 6, BURST_INCR, -1);      wait_burst(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
